// File: rtl/sdram_wb_bridge_if.sv
// Wishbone bus between the CPU and the SDRAM bridge.
// The CPU is the master, the bridge the slave.
interface sdram_wb_bridge_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [1:0]  wb_sel;
  logic [22:0] wb_adr;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack;
  logic        wb_err;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
    input  wb_dat_o, wb_ack, wb_err
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
    output wb_dat_o, wb_ack, wb_err
  );
endinterface

// File: rtl/sdram_wb_bridge.sv
// Wishbone slave to SDRAM controller request/ack bridge.
// One 16-bit word per bus cycle, with a watchdog bus error.
module sdram_wb_bridge #(
  parameter int RD_DLY  = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  sdram_wb_bridge_if.slave bus,
  input  logic             sdram_init_done,
  output logic             sdram_wr_req,
  output logic             sdram_rd_req,
  input  logic             sdram_wr_ack,
  input  logic             sdram_rd_ack,
  output logic [22:0]      sys_wraddr,
  output logic [22:0]      sys_rdaddr,
  output logic [15:0]      sys_data_in,
  input  logic [15:0]      sys_data_out,
  output logic [1:0]       sdram_byteenable,
  output logic [8:0]       sdwr_byte,
  output logic [8:0]       sdrd_byte
);

  localparam logic [2:0] DLY     = 3'(RD_DLY);
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic        r_wr_req;
  logic        r_rd_req;
  logic        r_ack;
  logic        r_err;
  logic [22:0] r_addr;
  logic [15:0] r_wdat;
  logic [15:0] r_rdat;
  logic [1:0]  r_be;
  logic [2:0]  r_cnt;
  logic [9:0]  r_wdog;

  logic        w_accept;
  logic        w_wd_hit;
  logic [9:0]  w_wdog_inc;

  // Blocking on our own ack/err stops a held strobe being re-taken.
  assign w_accept = bus.wb_cyc & bus.wb_stb & sdram_init_done
                  & ~r_ack & ~r_err;

  assign w_wd_hit   = (r_wdog == WD_LAST);
  assign w_wdog_inc = (&r_wdog) ? r_wdog : r_wdog + 10'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_wr_req <= 1'b0;
      r_rd_req <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdat   <= '0;
      r_rdat   <= '0;
      r_be     <= '0;
      r_cnt    <= '0;
      r_wdog   <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= bus.wb_adr;
            r_wdat   <= bus.wb_dat_i;
            r_be     <= bus.wb_we ? bus.wb_sel : 2'b11;
            r_we     <= bus.wb_we;
            r_wr_req <= bus.wb_we;
            r_rd_req <= ~bus.wb_we;
            r_wdog   <= '0;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          r_wdog <= w_wdog_inc;
          if (r_we && sdram_wr_ack) begin
            r_wr_req <= 1'b0;
            r_state  <= S_XFER;
          end else if (!r_we && sdram_rd_ack) begin
            r_rd_req <= 1'b0;
            r_cnt    <= 3'd1;
            if (DLY == 3'd0) begin
              r_rdat  <= sys_data_out;
              r_state <= S_DONE;
            end else begin
              r_state <= S_XFER;
            end
          end else if (w_wd_hit) begin
            r_wr_req <= 1'b0;
            r_rd_req <= 1'b0;
            r_err    <= bus.wb_cyc;
            r_state  <= S_ERR;
          end
        end
        S_XFER: begin
          r_wdog <= w_wdog_inc;
          if (r_we ? !sdram_wr_ack : (r_cnt == DLY)) begin
            if (!r_we) r_rdat <= sys_data_out;
            r_state <= S_DONE;
          end else if (w_wd_hit) begin
            r_err   <= bus.wb_cyc;
            r_state <= S_ERR;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_DONE: begin
          r_ack   <= bus.wb_cyc;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sdram_wr_req     = r_wr_req;
  assign sdram_rd_req     = r_rd_req;
  assign sys_wraddr       = r_addr;
  assign sys_rdaddr       = r_addr;
  assign sys_data_in      = r_wdat;
  assign sdram_byteenable = r_be;
  assign sdwr_byte        = 9'd1;
  assign sdrd_byte        = 9'd1;

  assign bus.wb_dat_o = r_rdat;
  assign bus.wb_ack   = r_ack;
  assign bus.wb_err   = r_err;

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Bench for sdram_wb_bridge: vector table, random traffic
// against a memory reference, and hand-written corner cases.
module tb_sdram_wb_bridge;

  localparam int RD_DLY  = 1;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sdram_init_done;
  logic        sdram_wr_req;
  logic        sdram_rd_req;
  logic        sdram_wr_ack;
  logic        sdram_rd_ack;
  logic [22:0] sys_wraddr;
  logic [22:0] sys_rdaddr;
  logic [15:0] sys_data_in;
  logic [15:0] sys_data_out;
  logic [1:0]  sdram_byteenable;
  logic [8:0]  sdwr_byte;
  logic [8:0]  sdrd_byte;

  sdram_wb_bridge_if wbif ();

  sdram_wb_bridge #(
    .RD_DLY  (RD_DLY),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (wbif),
    .sdram_init_done  (sdram_init_done),
    .sdram_wr_req     (sdram_wr_req),
    .sdram_rd_req     (sdram_rd_req),
    .sdram_wr_ack     (sdram_wr_ack),
    .sdram_rd_ack     (sdram_rd_ack),
    .sys_wraddr       (sys_wraddr),
    .sys_rdaddr       (sys_rdaddr),
    .sys_data_in      (sys_data_in),
    .sys_data_out     (sys_data_out),
    .sdram_byteenable (sdram_byteenable),
    .sdwr_byte        (sdwr_byte),
    .sdrd_byte        (sdrd_byte)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // controller model knobs and observations
  logic        ctl_en = 1'b1;
  int          ctl_lat = 0;
  int          ctl_hold = 1;
  logic        w_is_wr;
  logic [22:0] mw_addr, mr_addr;
  logic [15:0] mw_dat;
  logic [1:0]  mw_be, mr_be;
  int          wr_seen = 0;
  int          addr_viol = 0;

  // monitor observations
  int   cyc_n = 0;
  int   t_rdack = 0;
  int   t_wback = 0;
  int   ack_total = 0;
  int   err_total = 0;
  int   excl_viol = 0;
  logic prev_rd = 1'b0;

  logic [15:0] smem [logic [22:0]];
  logic [15:0] rmem [logic [22:0]];

  typedef struct {
    logic        we;
    logic [22:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [11];

  function automatic logic [15:0] dflt(input logic [22:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old,
                                        input logic [15:0] d,
                                        input logic [1:0]  be);
    return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  function automatic logic [15:0] s_rd(input logic [22:0] a);
    return smem.exists(a) ? smem[a] : dflt(a);
  endfunction

  function automatic logic [15:0] r_rd(input logic [22:0] a);
    return rmem.exists(a) ? rmem[a] : dflt(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // SDRAM controller: acks after ctl_lat cycles, holds write ack
  // ctl_hold cycles, returns read data the cycle after its ack.
  initial begin
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    sys_data_out = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (ctl_en && (sdram_wr_req || sdram_rd_req)) begin
        w_is_wr = sdram_wr_req;
        repeat (ctl_lat) @(negedge clk);
        if (sys_wraddr !== sys_rdaddr) addr_viol++;
        if (w_is_wr) begin
          mw_addr = sys_wraddr;
          mw_dat  = sys_data_in;
          mw_be   = sdram_byteenable;
          smem[mw_addr] = merge(s_rd(mw_addr), mw_dat, mw_be);
          wr_seen++;
          sdram_wr_ack = 1'b1;
          repeat (ctl_hold) @(negedge clk);
          sdram_wr_ack = 1'b0;
        end else begin
          mr_addr = sys_rdaddr;
          mr_be   = sdram_byteenable;
          sdram_rd_ack = 1'b1;
          @(negedge clk);
          sdram_rd_ack = 1'b0;
          sys_data_out = s_rd(mr_addr);
          @(negedge clk);
          sys_data_out = 16'hDEAD;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc_n++;
      if (sdram_rd_ack && !prev_rd) t_rdack = cyc_n;
      prev_rd = sdram_rd_ack;
      #1;
      if (wbif.wb_ack) begin
        ack_total++;
        t_wback = cyc_n;
      end
      if (wbif.wb_err) err_total++;
      if (sdram_wr_req && sdram_rd_req) excl_viol++;
    end
  end

  initial begin
    #200us;
    $display("FAIL tb_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  task automatic bus_start(input logic we, input logic [22:0] adr,
                           input logic [15:0] dat, input logic [1:0] sel);
    @(negedge clk);
    wbif.wb_cyc   = 1'b1;
    wbif.wb_stb   = 1'b1;
    wbif.wb_we    = we;
    wbif.wb_adr   = adr;
    wbif.wb_dat_i = dat;
    wbif.wb_sel   = sel;
  endtask

  task automatic bus_stop();
    wbif.wb_cyc = 1'b0;
    wbif.wb_stb = 1'b0;
  endtask

  task automatic wait_end(output logic gack, output logic gerr,
                          output logic [15:0] rdat);
    gack = 1'b0;
    gerr = 1'b0;
    rdat = '0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (wbif.wb_ack || wbif.wb_err) begin
        gack = wbif.wb_ack;
        gerr = wbif.wb_err;
        rdat = wbif.wb_dat_o;
        break;
      end
    end
  endtask

  task automatic do_txn(input logic we, input logic [22:0] adr,
                        input logic [15:0] dat, input logic [1:0] sel,
                        input logic [15:0] exp, input string tag);
    int          a0, e0;
    logic        gack, gerr;
    logic [15:0] rdat;
    a0 = ack_total;
    e0 = err_total;
    bus_start(we, adr, dat, sel);
    wait_end(gack, gerr, rdat);
    bus_stop();
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_ack_once"}, 64'(ack_total - a0), 64'd1);
    chk({tag, "_no_err"}, 64'(err_total - e0), 64'd0);
    if (we) begin
      chk({tag, "_wr_addr"}, 64'(mw_addr), 64'(adr));
      chk({tag, "_wr_data"}, 64'(mw_dat), 64'(dat));
      chk({tag, "_wr_be"}, 64'(mw_be), 64'(sel));
      rmem[adr] = merge(r_rd(adr), dat, sel);
    end else begin
      chk({tag, "_rd_addr"}, 64'(mr_addr), 64'(adr));
      chk({tag, "_rd_be"}, 64'(mr_be), 64'd3);
      chk({tag, "_rd_data"}, 64'(rdat), 64'(exp));
      chk({tag, "_rd_hold"}, 64'(wbif.wb_dat_o), 64'(exp));
      chk({tag, "_rd_lat"}, 64'(t_wback - t_rdack), 64'(RD_DLY + 1));
    end
  endtask

  initial begin
    logic [22:0] pool [8];
    logic [22:0] a;
    logic [15:0] d, exp, dat_before;
    logic [1:0]  s;
    logic        we, seen, gack, gerr, found;
    int          a0, e0, w0, n;

    tbl[0]  = '{1'b1, 23'h2A5F01, 16'hBEEF, 2'b10, 16'h0000};
    tbl[1]  = '{1'b0, 23'h2A5F01, 16'h0000, 2'b00, 16'hBE5B};
    tbl[2]  = '{1'b1, 23'h000003, 16'h1234, 2'b11, 16'h0000};
    tbl[3]  = '{1'b0, 23'h000003, 16'h0000, 2'b00, 16'h1234};
    tbl[4]  = '{1'b1, 23'h000003, 16'hAB00, 2'b10, 16'h0000};
    tbl[5]  = '{1'b0, 23'h000003, 16'h0000, 2'b01, 16'hAB34};
    tbl[6]  = '{1'b1, 23'h7FFFFF, 16'h00C3, 2'b01, 16'h0000};
    tbl[7]  = '{1'b0, 23'h7FFFFF, 16'h0000, 2'b00, 16'hA5C3};
    tbl[8]  = '{1'b0, 23'h400000, 16'h0000, 2'b00, 16'h5A5A};
    tbl[9]  = '{1'b1, 23'h400000, 16'hFFFF, 2'b00, 16'h0000};
    tbl[10] = '{1'b0, 23'h400000, 16'h0000, 2'b00, 16'h5A5A};

    rst_n           = 1'b0;
    sdram_init_done = 1'b0;
    wbif.wb_cyc     = 1'b0;
    wbif.wb_stb     = 1'b0;
    wbif.wb_we      = 1'b0;
    wbif.wb_sel     = 2'b00;
    wbif.wb_adr     = '0;
    wbif.wb_dat_i   = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_zero", 64'(|{sdram_wr_req, sdram_rd_req, wbif.wb_ack,
        wbif.wb_err, sdram_byteenable, sys_wraddr, sys_rdaddr,
        sys_data_in, wbif.wb_dat_o}), 64'd0);
    chk("rst_bytes", 64'({sdwr_byte, sdrd_byte}), 64'({9'd1, 9'd1}));
    @(negedge clk);
    rst_n = 1'b1;

    // init gating
    a0 = ack_total;
    bus_start(1'b1, 23'h000010, 16'h5555, 2'b11);
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (sdram_wr_req || sdram_rd_req || wbif.wb_ack) seen = 1'b1;
    end
    chk("init_gate_idle", 64'(seen), 64'd0);
    @(negedge clk);
    sdram_init_done = 1'b1;
    @(posedge clk);
    #1;
    chk("init_req_1cyc", 64'(sdram_wr_req), 64'd1);
    wait_end(gack, gerr, d);
    bus_stop();
    chk("init_wr_ack", 64'(gack), 64'd1);
    rmem[23'h000010] = 16'h5555;

    for (int i = 0; i < 11; i++) begin
      do_txn(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel,
             tbl[i].exp, $sformatf("vec%0d", i));
    end

    // random traffic against the reference memory
    for (int i = 0; i < 8; i++) pool[i] = 23'($urandom);
    pool[0] = 23'h000003;
    for (int i = 0; i < 60; i++) begin
      ctl_lat  = $urandom_range(0, 2);
      ctl_hold = $urandom_range(1, 3);
      we  = 1'($urandom_range(0, 1));
      a   = pool[$urandom_range(0, 7)];
      d   = 16'($urandom);
      s   = 2'($urandom);
      exp = r_rd(a);
      do_txn(we, a, d, s, exp, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    ctl_lat  = 0;
    ctl_hold = 1;

    // watchdog: read never acknowledged
    dat_before = wbif.wb_dat_o;
    ctl_en = 1'b0;
    bus_start(1'b0, 23'h000777, 16'h0000, 2'b11);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (sdram_rd_req) begin
        found = 1'b1;
        break;
      end
    end
    chk("to_req_seen", 64'(found), 64'd1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (wbif.wb_err) break;
    end
    chk("to_err_cycle", 64'(n), 64'(TIMEOUT));
    chk("to_req_drop", 64'(sdram_rd_req), 64'd0);
    bus_stop();
    @(posedge clk);
    #1;
    chk("to_err_pulse", 64'(wbif.wb_err), 64'd0);
    chk("to_dat_kept", 64'(wbif.wb_dat_o), 64'(dat_before));
    ctl_en = 1'b1;
    do_txn(1'b1, 23'h1F00AA, 16'h6789, 2'b11, 16'h0000, "to_next_wr");

    // reset while a read sits in XFER
    bus_start(1'b0, 23'h123456, 16'h0000, 2'b11);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (sdram_rd_ack) begin
        found = 1'b1;
        break;
      end
    end
    chk("mr_ack_seen", 64'(found), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_zero", 64'(|{sdram_wr_req, sdram_rd_req, wbif.wb_ack,
        wbif.wb_err, sdram_byteenable, sys_wraddr, sys_rdaddr,
        sys_data_in, wbif.wb_dat_o}), 64'd0);
    chk("mr_bytes", 64'({sdwr_byte, sdrd_byte}), 64'({9'd1, 9'd1}));
    bus_stop();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    a0 = ack_total;
    repeat (10) @(posedge clk);
    #1;
    chk("mr_no_ack", 64'(ack_total - a0), 64'd0);
    chk("mr_dat_zero", 64'(wbif.wb_dat_o), 64'd0);

    // wb_cyc dropped while the write request is pending
    ctl_lat  = 2;
    ctl_hold = 2;
    w0 = wr_seen;
    a0 = ack_total;
    e0 = err_total;
    bus_start(1'b1, 23'h0A0B0C, 16'hC0DE, 2'b11);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (sdram_wr_req) begin
        found = 1'b1;
        break;
      end
    end
    chk("cd_req_seen", 64'(found), 64'd1);
    bus_stop();
    repeat (20) @(posedge clk);
    #1;
    chk("cd_write_done", 64'(wr_seen - w0), 64'd1);
    chk("cd_no_ack", 64'(ack_total - a0), 64'd0);
    chk("cd_no_err", 64'(err_total - e0), 64'd0);
    rmem[23'h0A0B0C] = 16'hC0DE;
    ctl_lat  = 0;
    ctl_hold = 1;
    do_txn(1'b0, 23'h0A0B0C, 16'h0000, 2'b11, r_rd(23'h0A0B0C), "cd_rdback");

    chk("req_exclusive", 64'(excl_viol), 64'd0);
    chk("addr_mirror", 64'(addr_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
